// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared opcodes, ALU encodings, field widths and FSM states.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int OPC_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_sequencer_instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode                                                         |
// | Combinational opcode decoder; outputs are ungated control enables.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic [2:0]       alu_op_o,
  output logic             acc_we_en_o,
  output logic             out_we_en_o,
  output logic             jmp_o,
  output logic             jz_o,
  output logic             halt_o,
  output logic             illegal_o
);

  always_comb begin
    alu_op_o    = ALU_PASS;
    acc_we_en_o = 1'b0;
    out_we_en_o = 1'b0;
    jmp_o       = 1'b0;
    jz_o        = 1'b0;
    halt_o      = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OP_NOP:  ;
      OP_LDI:  begin alu_op_o = ALU_PASS; acc_we_en_o = 1'b1; end
      OP_ADD:  begin alu_op_o = ALU_ADD;  acc_we_en_o = 1'b1; end
      OP_SUB:  begin alu_op_o = ALU_SUB;  acc_we_en_o = 1'b1; end
      OP_AND:  begin alu_op_o = ALU_AND;  acc_we_en_o = 1'b1; end
      OP_OR:   begin alu_op_o = ALU_OR;   acc_we_en_o = 1'b1; end
      OP_XOR:  begin alu_op_o = ALU_XOR;  acc_we_en_o = 1'b1; end
      OP_JMP:  jmp_o       = 1'b1;
      OP_JZ:   jz_o        = 1'b1;
      OP_OUT:  out_we_en_o = 1'b1;
      OP_HALT: halt_o      = 1'b1;
      // 0xA..0xE behave as NOP but are flagged
      default: illegal_o   = 1'b1;
    endcase
  end

endmodule : instr_decode
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_sequencer                                                        |
// | Fetch/decode/execute control unit: owns pc, ir and datapath strobes.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ir,
  input  logic                   zero_flag,
  output logic [2:0]             alu_op,
  output logic                   acc_we,
  output logic                   out_we,
  output logic                   halted,
  output logic                   illegal
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   illegal_q, illegal_d;

  logic [2:0]             w_dec_alu_op;
  logic                   w_dec_acc_we, w_dec_out_we;
  logic                   w_dec_jmp, w_dec_jz, w_dec_halt, w_dec_illegal;
  logic                   w_exec, w_fetch_ack, w_take_jump;
  logic [PC_WIDTH-1:0]    w_jump_target;

  instr_decode u_instr_decode (
    .opcode_i    (ir_q[INSTR_WIDTH-1 -: OPC_W]),
    .alu_op_o    (w_dec_alu_op),
    .acc_we_en_o (w_dec_acc_we),
    .out_we_en_o (w_dec_out_we),
    .jmp_o       (w_dec_jmp),
    .jz_o        (w_dec_jz),
    .halt_o      (w_dec_halt),
    .illegal_o   (w_dec_illegal)
  );

  assign w_exec        = (state_q == EXECUTE);
  assign w_fetch_ack   = imem_req & imem_ack;
  assign w_take_jump   = w_exec & (w_dec_jmp | (w_dec_jz & zero_flag));
  assign w_jump_target = PC_WIDTH'(ir_q[DATA_W-1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (w_fetch_ack) state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = w_dec_halt ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // pc / ir / sticky illegal; a jump overrides the increment done in FETCH
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q | (w_exec & w_dec_illegal);
    if (w_fetch_ack) begin
      ir_d = imem_rdata;
      pc_d = pc_q + 1'b1;
    end
    if (w_take_jump) begin
      pc_d = w_jump_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Output logic; request is masked by rst_n so reset drops it at once
  always_comb begin
    imem_req  = (state_q == FETCH) & rst_n;
    imem_addr = pc_q;
    ir        = ir_q;
    alu_op    = w_exec ? w_dec_alu_op : ALU_PASS;
    acc_we    = w_exec & w_dec_acc_we;
    out_we    = w_exec & w_dec_out_we;
    halted    = (state_q == HALT);
    illegal   = illegal_q | (w_exec & w_dec_illegal);
  end

endmodule : cpu_sequencer
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_sequencer                                                     |
// | Directed bench with a simple program memory and hand-derived values.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_rdata;
  logic [11:0] ir;
  logic        zero_flag;
  logic [2:0]  alu_op;
  logic        acc_we;
  logic        out_we;
  logic        halted;
  logic        illegal;

  logic [11:0] mem [256];
  int          errors;
  int          checks;
  int          cyc;

  cpu_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .zero_flag  (zero_flag),
    .alu_op     (alu_op),
    .acc_we     (acc_we),
    .out_we     (out_we),
    .halted     (halted),
    .illegal    (illegal)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  // Leaves the bench 1 time unit into cycle 1 (first FETCH after release)
  task automatic do_reset();
    rst_n     = 1'b0;
    imem_ack  = 1'b0;
    zero_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc = 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    imem_ack  = 1'b0;
    zero_flag = 1'b0;
    clear_mem();

    // Reset values
    #12;
    chk("rst_req",     imem_req, 0);
    chk("rst_addr",    imem_addr, 0);
    chk("rst_ir",      ir, 0);
    chk("rst_alu",     alu_op, 0);
    chk("rst_acc_we",  acc_we, 0);
    chk("rst_out_we",  out_we, 0);
    chk("rst_halted",  halted, 0);
    chk("rst_illegal", illegal, 0);

    // LDI 5 / ADD 3 / OUT / HALT with ack tied high
    clear_mem();
    mem[0] = 12'h105; mem[1] = 12'h203; mem[2] = 12'h900; mem[3] = 12'hF00;
    do_reset();
    imem_ack = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      logic exp_req;
      exp_req = (c == 1) || (c == 4) || (c == 7) || (c == 10);
      chk("prog_req",    imem_req, exp_req);
      if (exp_req) chk("prog_addr", imem_addr, (c - 1) / 3);
      chk("prog_acc_we", acc_we, (c == 3) || (c == 6));
      chk("prog_out_we", out_we, c == 9);
      chk("prog_halted", halted, c >= 13);
      if (c == 2) chk("prog_ir_decode", ir, 12'h105);
      if (c == 3) chk("prog_alu_ldi", alu_op, 0);
      if (c == 6) chk("prog_alu_add", alu_op, 1);
      if (c == 5) chk("prog_alu_idle", alu_op, 0);
      step();
    end

    // Four wait cycles before the ack at address 0
    clear_mem();
    mem[0] = 12'h900;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      chk("wait_req",  imem_req, 1);
      chk("wait_addr", imem_addr, 0);
      chk("wait_ir",   ir, 0);
      if (c == 5) imem_ack = 1'b1;
      step();
    end
    imem_ack = 1'b0;
    chk("wait_decode_req", imem_req, 0);
    chk("wait_decode_ir",  ir, 12'h900);
    chk("wait_decode_out", out_we, 0);
    step();
    chk("wait_exec_out", out_we, 1);

    // JZ taken then not taken
    clear_mem();
    mem[0] = 12'h840; mem[8'h40] = 12'h840; mem[8'h41] = 12'hF00;
    do_reset();
    imem_ack  = 1'b1;
    zero_flag = 1'b1;
    repeat (3) step();
    chk("jz_taken_req",  imem_req, 1);
    chk("jz_taken_addr", imem_addr, 8'h40);
    zero_flag = 1'b0;
    repeat (3) step();
    chk("jz_not_req",  imem_req, 1);
    chk("jz_not_addr", imem_addr, 8'h41);

    // JMP 0xFF then NOP wraps pc
    clear_mem();
    mem[0] = 12'h7FF; mem[8'hFF] = 12'h000;
    do_reset();
    imem_ack = 1'b1;
    repeat (3) step();
    chk("jmp_addr", imem_addr, 8'hFF);
    repeat (3) step();
    chk("wrap_req",  imem_req, 1);
    chk("wrap_addr", imem_addr, 8'h00);

    // Illegal opcode 0xB
    clear_mem();
    mem[0] = 12'hB00; mem[1] = 12'h105;
    do_reset();
    imem_ack = 1'b1;
    step();
    chk("ill_decode_flag", illegal, 0);
    step();
    chk("ill_exec_flag",   illegal, 1);
    chk("ill_exec_acc_we", acc_we, 0);
    chk("ill_exec_out_we", out_we, 0);
    chk("ill_exec_alu",    alu_op, 0);
    step();
    chk("ill_next_req",  imem_req, 1);
    chk("ill_next_addr", imem_addr, 1);
    chk("ill_sticky",    illegal, 1);
    repeat (2) step();
    chk("ill_continue_acc_we", acc_we, 1);
    chk("ill_still_set",       illegal, 1);

    // Reset while a fetch is pending
    clear_mem();
    mem[0] = 12'h105; mem[1] = 12'h203;
    do_reset();
    imem_ack = 1'b1;
    repeat (2) step();
    imem_ack = 1'b0;
    step();
    chk("midrst_pre_req",  imem_req, 1);
    chk("midrst_pre_addr", imem_addr, 1);
    chk("midrst_pre_ir",   ir, 12'h105);
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("midrst_req",  imem_req, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_ir",   ir, 0);
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    #1;
    cyc = 1;
    chk("midrst_rel_req",  imem_req, 1);
    chk("midrst_rel_addr", imem_addr, 0);
    chk("midrst_rel_ir",   ir, 0);
    step();
    chk("midrst_hold_addr", imem_addr, 0);
    chk("midrst_hold_ir",   ir, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cpu_sequencer
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/execute control unit for the Tiny-CPU. It fetches 12-bit instruction words from program memory over a request/acknowledge handshake and owns the program counter and instruction register. The instruction register feeds the bus splitter: opcode in bits [11:8], immediate data in bits [7:0]. The block also issues one-cycle ALU and write strobes to the datapath.

## Interface
- PC_WIDTH, 8, program counter and instruction-address width
- INSTR_WIDTH, 12, instruction word width; fixed split of 4-bit opcode and 8-bit data
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to program memory
- imem_addr  out  PC_WIDTH  fetch address; equals pc
- imem_ack  in  1  read data valid for this cycle
- imem_rdata  in  INSTR_WIDTH  instruction word, sampled when imem_req && imem_ack
- ir  out  INSTR_WIDTH  instruction register; drives the bus splitter input
- zero_flag  in  1  accumulator-zero flag from the datapath
- alu_op  out  3  ALU function select
- acc_we  out  1  accumulator write strobe
- out_we  out  1  output-port write strobe
- halted  out  1  core has executed HALT
- illegal  out  1  sticky flag: an undefined opcode was executed

## Operation
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Opcodes:
  - 0 NOP
  - 1 LDI: alu_op=PASS, acc_we
  - 2 ADD: alu_op=ADD, acc_we
  - 3 SUB: alu_op=SUB, acc_we
  - 4 AND: alu_op=AND, acc_we
  - 5 OR: alu_op=OR, acc_we
  - 6 XOR: alu_op=XOR, acc_we
  - 7 JMP: pc<=data
  - 8 JZ: pc<=data if zero_flag
  - 9 OUT: out_we
  - F HALT
  - A–E are illegal: execute as NOP and set illegal.
- States:
  - FETCH: imem_req=1 and imem_addr=pc. Wait for imem_ack. On ack: ir<=imem_rdata, pc<=pc+1, go to DECODE.
  - DECODE: one cycle with no strobes. Go to EXECUTE.
  - EXECUTE: one cycle. Strobes are asserted per the opcode. Jumps load pc. Next state is HALT if the opcode is F, otherwise FETCH.
  - HALT: terminal state with halted=1 and no requests. Only rst_n leaves HALT.
- Handshake rules:
  - Once imem_req rises, it stays high with imem_addr stable until the cycle imem_ack is seen.
  - imem_ack outside FETCH is ignored.
- Arithmetic: pc increments modulo 2^PC_WIDTH, so 0xFF wraps to 0x00 with no flag. A jump target overrides the increment already applied in FETCH.
- Strobe decoding:
  - alu_op, acc_we and out_we are decoded from the registered state and ir only, so they are glitch-free.
  - Outside EXECUTE: acc_we=0, out_we=0, alu_op=PASS (0).
- JZ samples zero_flag in the EXECUTE cycle. The datapath guarantees the flag reflects all prior writes by then.

## Timing
- Reset values, applied immediately on rst_n low: state=FETCH, pc=0, ir=0, alu_op=0, acc_we=0, out_we=0, halted=0, illegal=0.
- imem_req is 1 in the first cycle after reset release.
- Instruction latency is 3 cycles minimum: FETCH with same-cycle ack, then DECODE, then EXECUTE. Each wait cycle in FETCH adds one cycle.
- The ir update is visible in the DECODE cycle. Strobes are valid for exactly the single EXECUTE cycle.
- The pc update from a jump is visible in the following FETCH cycle as imem_addr.
- Reset asserted mid-fetch drops imem_req asynchronously and discards the pending fetch. A late ack after reset is ignored until the FETCH state asserts imem_req again.
- illegal stays set until reset; execution continues after an illegal opcode.

## Structure
- The shared package cpu_pkg holds:
  - opcode constants OP_NOP..OP_HALT
  - alu_op encodings ALU_PASS=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5
  - the state enum FETCH, DECODE, EXECUTE, HALT
  - instruction field widths (4/8)
- Sub-module instr_decode is purely combinational: opcode in; alu_op, acc_we_en, out_we_en, jmp, jz, halt, illegal out. The sequencer gates its outputs with the EXECUTE state.

## Test plan
- Reset then program LDI 0x05 (0x105), ADD 0x03 (0x203), OUT (0x900), HALT (0xF00) with ack tied high. Required: addresses 0,1,2,3 are requested; acc_we pulses at cycles 3 and 6; out_we pulses at cycle 9; halted=1 at cycle 13 and stays high; imem_req stays 0 thereafter.
- Insert 4 wait cycles before ack at address 0. Required: imem_req and imem_addr=0 are held stable for all 5 cycles; the DECODE cycle follows the ack cycle.
- JZ 0x40 (0x840) with zero_flag=1, then again with zero_flag=0. Required: the next imem_addr is 0x40 in the first case and pc+1 in the second.
- JMP 0xFF (0x7FF), then NOP at address 0xFF. Required: the next fetch address wraps to 0x00.
- Opcode 0xB at any address. Required: illegal=1 from EXECUTE onward, no strobes, and fetching continues at the next address.
- Assert rst_n low while imem_req=1 and ack is pending. Required: imem_req=0, pc=0 and ir=0 immediately; the first request after release is to address 0.
